// File: rtl/ALUControl_Defines.sv
// ALU operation encodings shared by the decode-stage ALU decoder and the EX-stage ALU.
package alu_control_defines;

  localparam logic [3:0] ALU_SUM  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_ROR  = 4'b1010;

endpackage

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: pipeline register layouts and forwarding select.
package exec_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM
  } fwd_sel_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic              branch;
    logic              jump;
    logic [3:0]        alu_control;
    logic              alu_src;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
  } id_ex_t;

  typedef struct packed {
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   write_data;
    logic [XLEN-1:0]   pc_plus4;
  } ex_mem_t;

  // The MEM stage holds the younger result, so it is checked first; x0 never forwards.
  function automatic fwd_sel_t fwd_select(
    input logic              reg_write_m,
    input logic [REG_AW-1:0] rd_m,
    input logic              reg_write_w,
    input logic [REG_AW-1:0] rd_w,
    input logic [REG_AW-1:0] rs
  );
    if (reg_write_m && (rd_m != '0) && (rd_m == rs))
      return FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational 32-bit ALU driven by the decode-stage ALUControl code.
module alu
  import exec_pkg::*;
  import alu_control_defines::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic [4:0]        shamt;
  logic [2*XLEN-1:0] rot_full;

  assign shamt    = b[4:0];
  // Rotating right is a right shift of the operand concatenated with itself.
  assign rot_full = {a, a} >> shamt;

  always_comb begin
    result = '0;
    case (alu_control)
      ALU_SUM:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_ROR:  result = rot_full[XLEN-1:0];
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Pipeline EX stage: ID/EX register, MEM/WB operand forwarding, ALU, branch/jump resolution, EX/MEM register.
module execute_stage
  import exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic [3:0]        alu_control_d,
  input  logic              alu_src_d,
  input  logic              reg_write_d,
  input  logic              mem_write_d,
  input  logic [1:0]        result_src_d,
  input  logic              branch_d,
  input  logic              jump_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [XLEN-1:0]   imm_ext_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   alu_result_m_fw,
  input  logic [REG_AW-1:0] rd_m_fw,
  input  logic              reg_write_m_fw,
  input  logic [XLEN-1:0]   result_w,
  input  logic [REG_AW-1:0] rd_w,
  input  logic              reg_write_w,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic              pc_src_e,
  output logic [XLEN-1:0]   pc_target_e,
  output logic [XLEN-1:0]   alu_result_m,
  output logic [XLEN-1:0]   write_data_m,
  output logic [XLEN-1:0]   pc_plus4_m,
  output logic [REG_AW-1:0] rd_m,
  output logic              reg_write_m,
  output logic              mem_write_m,
  output logic [1:0]        result_src_m
);

  id_ex_t          id_ex;
  ex_mem_t         ex_mem;
  fwd_sel_t        fwd_a_sel, fwd_b_sel;
  logic [XLEN-1:0] fwd_a, fwd_b, src_b, alu_out;
  logic            alu_zero;

  // Flush outranks stall so a load-use bubble is inserted even while decode is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex <= '0;
    end else if (flush_e) begin
      id_ex <= '0;
    end else if (!stall_e) begin
      id_ex.reg_write   <= reg_write_d;
      id_ex.mem_write   <= mem_write_d;
      id_ex.result_src  <= result_src_d;
      id_ex.branch      <= branch_d;
      id_ex.jump        <= jump_d;
      id_ex.alu_control <= alu_control_d;
      id_ex.alu_src     <= alu_src_d;
      id_ex.rs1         <= rs1_d;
      id_ex.rs2         <= rs2_d;
      id_ex.rd          <= rd_d;
      id_ex.rd1         <= rd1_d;
      id_ex.rd2         <= rd2_d;
      id_ex.imm         <= imm_ext_d;
      id_ex.pc          <= pc_d;
    end
  end

  always_comb begin
    fwd_a_sel = fwd_select(reg_write_m_fw, rd_m_fw, reg_write_w, rd_w, id_ex.rs1);
    fwd_b_sel = fwd_select(reg_write_m_fw, rd_m_fw, reg_write_w, rd_w, id_ex.rs2);

    fwd_a = id_ex.rd1;
    case (fwd_a_sel)
      FWD_MEM: fwd_a = alu_result_m_fw;
      FWD_WB:  fwd_a = result_w;
      default: fwd_a = id_ex.rd1;
    endcase

    fwd_b = id_ex.rd2;
    case (fwd_b_sel)
      FWD_MEM: fwd_b = alu_result_m_fw;
      FWD_WB:  fwd_b = result_w;
      default: fwd_b = id_ex.rd2;
    endcase

    src_b = id_ex.alu_src ? id_ex.imm : fwd_b;
  end

  alu u_alu (
    .a           (fwd_a),
    .b           (src_b),
    .alu_control (id_ex.alu_control),
    .result      (alu_out),
    .zero        (alu_zero)
  );

  assign pc_src_e    = (id_ex.branch & alu_zero) | id_ex.jump;
  assign pc_target_e = id_ex.pc + id_ex.imm;

  // EX/MEM never stalls; a held instruction is simply re-registered each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_mem <= '0;
    end else begin
      ex_mem.reg_write  <= id_ex.reg_write;
      ex_mem.mem_write  <= id_ex.mem_write;
      ex_mem.result_src <= id_ex.result_src;
      ex_mem.rd         <= id_ex.rd;
      ex_mem.alu_result <= alu_out;
      ex_mem.write_data <= fwd_b;
      ex_mem.pc_plus4   <= id_ex.pc + 32'd4;
    end
  end

  assign rs1_e        = id_ex.rs1;
  assign rs2_e        = id_ex.rs2;
  assign rd_e         = id_ex.rd;
  assign alu_result_m = ex_mem.alu_result;
  assign write_data_m = ex_mem.write_data;
  assign pc_plus4_m   = ex_mem.pc_plus4;
  assign rd_m         = ex_mem.rd;
  assign reg_write_m  = ex_mem.reg_write;
  assign mem_write_m  = ex_mem.mem_write;
  assign result_src_m = ex_mem.result_src;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU vector table plus hand-written reset, forwarding, branch and stall sequences.
module tb_execute_stage;
  import alu_control_defines::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_e, flush_e;
  logic [3:0]  alu_control_d;
  logic        alu_src_d, reg_write_d, mem_write_d;
  logic [1:0]  result_src_d;
  logic        branch_d, jump_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic [31:0] rd1_d, rd2_d, imm_ext_d, pc_d;
  logic [31:0] alu_result_m_fw;
  logic [4:0]  rd_m_fw;
  logic        reg_write_m_fw;
  logic [31:0] result_w;
  logic [4:0]  rd_w;
  logic        reg_write_w;
  logic [4:0]  rs1_e, rs2_e, rd_e;
  logic        pc_src_e;
  logic [31:0] pc_target_e, alu_result_m, write_data_m, pc_plus4_m;
  logic [4:0]  rd_m;
  logic        reg_write_m, mem_write_m;
  logic [1:0]  result_src_m;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expected;
  } alu_vec_t;

  alu_vec_t aluVecs[12];

  always #5 clk = ~clk;

  execute_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_e         (stall_e),
    .flush_e         (flush_e),
    .alu_control_d   (alu_control_d),
    .alu_src_d       (alu_src_d),
    .reg_write_d     (reg_write_d),
    .mem_write_d     (mem_write_d),
    .result_src_d    (result_src_d),
    .branch_d        (branch_d),
    .jump_d          (jump_d),
    .rs1_d           (rs1_d),
    .rs2_d           (rs2_d),
    .rd_d            (rd_d),
    .rd1_d           (rd1_d),
    .rd2_d           (rd2_d),
    .imm_ext_d       (imm_ext_d),
    .pc_d            (pc_d),
    .alu_result_m_fw (alu_result_m_fw),
    .rd_m_fw         (rd_m_fw),
    .reg_write_m_fw  (reg_write_m_fw),
    .result_w        (result_w),
    .rd_w            (rd_w),
    .reg_write_w     (reg_write_w),
    .rs1_e           (rs1_e),
    .rs2_e           (rs2_e),
    .rd_e            (rd_e),
    .pc_src_e        (pc_src_e),
    .pc_target_e     (pc_target_e),
    .alu_result_m    (alu_result_m),
    .write_data_m    (write_data_m),
    .pc_plus4_m      (pc_plus4_m),
    .rd_m            (rd_m),
    .reg_write_m     (reg_write_m),
    .mem_write_m     (mem_write_m),
    .result_src_m    (result_src_m)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    stall_e = 0; flush_e = 0;
    alu_control_d = ALU_SUM; alu_src_d = 0; reg_write_d = 0; mem_write_d = 0;
    result_src_d = 0; branch_d = 0; jump_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0;
    rd1_d = 0; rd2_d = 0; imm_ext_d = 0; pc_d = 0;
    alu_result_m_fw = 0; rd_m_fw = 0; reg_write_m_fw = 0;
    result_w = 0; rd_w = 0; reg_write_w = 0;
  endtask

  // Sets up an R-type op in decode with forwarding idle, then lets it reach EX/MEM.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    clearInputs();
    alu_control_d = op; rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd3; reg_write_d = 1;
    rd1_d = a; rd2_d = b;
    tick();
    tick();
  endtask

  initial begin
    aluVecs[0]  = '{"sum",  ALU_SUM,  32'h8000_0001, 32'h4, 32'h8000_0005};
    aluVecs[1]  = '{"sub",  ALU_SUB,  32'h8000_0001, 32'h4, 32'h7FFF_FFFD};
    aluVecs[2]  = '{"sll",  ALU_SLL,  32'h8000_0001, 32'h4, 32'h0000_0010};
    aluVecs[3]  = '{"srl",  ALU_SRL,  32'h8000_0001, 32'h4, 32'h0800_0000};
    aluVecs[4]  = '{"sra",  ALU_SRA,  32'h8000_0001, 32'h4, 32'hF800_0000};
    aluVecs[5]  = '{"ror",  ALU_ROR,  32'h8000_0001, 32'h4, 32'h1800_0000};
    aluVecs[6]  = '{"slt",  ALU_SLT,  32'h8000_0001, 32'h4, 32'h0000_0001};
    aluVecs[7]  = '{"sltu", ALU_SLTU, 32'h8000_0001, 32'h4, 32'h0000_0000};
    aluVecs[8]  = '{"xor",  ALU_XOR,  32'h8000_0001, 32'h4, 32'h8000_0005};
    aluVecs[9]  = '{"or",   ALU_OR,   32'h8000_0001, 32'h4, 32'h8000_0005};
    aluVecs[10] = '{"and",  ALU_AND,  32'h8000_0001, 32'h4, 32'h0000_0000};
    aluVecs[11] = '{"undef",4'b1111,  32'h8000_0001, 32'h4, 32'h0000_0000};

    clearInputs();
    rst_n = 0;
    tick();
    checkOutput("reset_reg_write_m", {31'd0, reg_write_m}, 32'd0);
    checkOutput("reset_rd_e", {27'd0, rd_e}, 32'd0);
    rst_n = 1;

    // Reset mid-stream: in-flight writer must vanish immediately.
    applyStimulus(ALU_SUM, 32'd10, 32'd20);
    checkOutput("pre_reset_result", alu_result_m, 32'd30);
    #2 rst_n = 0;
    #1;
    checkOutput("async_reset_result", alu_result_m, 32'd0);
    checkOutput("async_reset_reg_write_m", {31'd0, reg_write_m}, 32'd0);
    checkOutput("async_reset_rd_e", {27'd0, rd_e}, 32'd0);
    tick();
    rst_n = 1;
    rd_d = 5'd11; reg_write_d = 1; rd1_d = 32'd5; rd2_d = 32'd6;
    tick();
    checkOutput("post_reset_rd_e", {27'd0, rd_e}, 32'd11);
    checkOutput("post_reset_not_yet_m", alu_result_m, 32'd0);
    tick();
    checkOutput("post_reset_result", alu_result_m, 32'd11);

    foreach (aluVecs[i]) begin
      applyStimulus(aluVecs[i].op, aluVecs[i].a, aluVecs[i].b);
      checkOutput({"alu_", aluVecs[i].name}, alu_result_m, aluVecs[i].expected);
    end

    // Forwarding: add x6,x5,x5 with stale RF data of 0.
    clearInputs();
    alu_control_d = ALU_SUM; rs1_d = 5; rs2_d = 5; rd_d = 6; reg_write_d = 1;
    alu_result_m_fw = 32'd7; rd_m_fw = 5; reg_write_m_fw = 1;
    tick(); tick();
    checkOutput("fwd_mem", alu_result_m, 32'd14);
    reg_write_m_fw = 0; result_w = 32'd7; rd_w = 5; reg_write_w = 1;
    tick(); tick();
    checkOutput("fwd_wb", alu_result_m, 32'd14);
    alu_result_m_fw = 32'd9; reg_write_m_fw = 1;
    tick(); tick();
    checkOutput("fwd_mem_beats_wb", alu_result_m, 32'd18);
    rs1_d = 0; rs2_d = 0; rd1_d = 1; rd2_d = 1; rd_m_fw = 0; rd_w = 0;
    tick(); tick();
    checkOutput("fwd_x0_blocked", alu_result_m, 32'd2);

    // Branch and jump resolution.
    clearInputs();
    alu_control_d = ALU_SUB; branch_d = 1; rs1_d = 1; rs2_d = 2;
    rd1_d = 3; rd2_d = 3; pc_d = 32'h100; imm_ext_d = 32'h20;
    tick();
    checkOutput("beq_taken", {31'd0, pc_src_e}, 32'd1);
    checkOutput("beq_target", pc_target_e, 32'h120);
    rd2_d = 4;
    tick();
    checkOutput("beq_not_taken", {31'd0, pc_src_e}, 32'd0);
    branch_d = 0; jump_d = 1; reg_write_d = 1; rd_d = 1; rd2_d = 3;
    tick();
    checkOutput("jal_pc_src", {31'd0, pc_src_e}, 32'd1);
    tick();
    checkOutput("jal_pc_plus4", pc_plus4_m, 32'h104);

    // Stall holds, flush overrides stall.
    clearInputs();
    rs1_d = 7; rd_d = 9; reg_write_d = 1; mem_write_d = 1;
    tick();
    rs1_d = 3; rd_d = 4; stall_e = 1;
    tick(); tick();
    checkOutput("stall_rs1_e", {27'd0, rs1_e}, 32'd7);
    checkOutput("stall_rd_e", {27'd0, rd_e}, 32'd9);
    checkOutput("stall_reexec_reg_write_m", {31'd0, reg_write_m}, 32'd1);
    flush_e = 1;
    tick();
    checkOutput("flush_rd_e", {27'd0, rd_e}, 32'd0);
    clearInputs();
    tick();
    checkOutput("flush_reg_write_m", {31'd0, reg_write_m}, 32'd0);
    checkOutput("flush_mem_write_m", {31'd0, mem_write_m}, 32'd0);

    // Store with rs2 forwarded from MEM.
    clearInputs();
    alu_control_d = ALU_SUM; alu_src_d = 1; mem_write_d = 1;
    rs1_d = 2; rs2_d = 3; rd1_d = 32'h1000; rd2_d = 0; imm_ext_d = 8;
    alu_result_m_fw = 32'hDEAD_BEEF; rd_m_fw = 3; reg_write_m_fw = 1;
    tick(); tick();
    checkOutput("store_write_data", write_data_m, 32'hDEAD_BEEF);
    checkOutput("store_address", alu_result_m, 32'h1008);
    checkOutput("store_mem_write_m", {31'd0, mem_write_m}, 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
